// File: rtl/viterbi_pkg.sv
// Shared trellis definitions for the convolutional encoder and the Viterbi decoder.
// Both sides of the link import this package, so they always agree on the
// constraint length and the two generator polynomials.
//   K          : constraint length (K-1 memory bits)
//   G0, G1     : generator polynomials; MSB taps the newest (incoming) bit
//   NUM_STATES : trellis state count, 2**(K-1)
//   enc_state_e: encoder frame-sequencing states
package viterbi_pkg;

  localparam int K = 3;
  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;
  localparam int NUM_STATES = 1 << (K - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAIL
  } enc_state_e;

endpackage

// File: rtl/conv_encoder_if.sv
// Handshake bundle between a bit source/sink and the convolutional encoder.
//   in_valid/in_ready/in_bit/in_last : information-bit stream into the encoder
//   out_valid/out_ready/out_sym/out_last : code-symbol stream out of the encoder
//   frame_done : one-cycle pulse after the final symbol of a frame is taken
//   sym_count  : symbols accepted downstream in the current frame
// The encoder uses the slave modport; the driving environment uses master.
interface conv_encoder_if;

  logic        in_valid;
  logic        in_ready;
  logic        in_bit;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_sym;
  logic        out_last;
  logic        frame_done;
  logic [15:0] sym_count;

  modport master (
    output in_valid, in_bit, in_last, out_ready,
    input  in_ready, out_valid, out_sym, out_last, frame_done, sym_count
  );

  modport slave (
    input  in_valid, in_bit, in_last, out_ready,
    output in_ready, out_valid, out_sym, out_last, frame_done, sym_count
  );

endinterface

// File: rtl/conv_encoder_parity.sv
// Single generator-polynomial parity: XOR of the tap bits selected by the
// polynomial.
//   i_taps   : {newest bit, shift-register contents}
//   i_poly   : generator polynomial, bit-aligned with i_taps
//   o_parity : resulting code bit
module conv_parity #(
  parameter int K = 3
) (
  input  logic [K-1:0] i_taps,
  input  logic [K-1:0] i_poly,
  output logic         o_parity
);

  assign o_parity = ^(i_taps & i_poly);

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 feed-forward convolutional encoder with frame termination.
// Each accepted information bit yields one 2-bit code symbol; after the bit
// flagged in_last, K-1 zero bits are pushed through so the register ends at
// all zeros and the decoder can finish in the zero state.
//   clk, rst : single clock, asynchronous active-high reset
//   bus      : conv_encoder_if.slave (input stream, output stream, status)
module conv_encoder #(
  parameter int           K  = viterbi_pkg::K,
  parameter logic [K-1:0] G0 = viterbi_pkg::G0,
  parameter logic [K-1:0] G1 = viterbi_pkg::G1
) (
  input  logic          clk,
  input  logic          rst,
  conv_encoder_if.slave bus
);

  import viterbi_pkg::*;

  localparam int             TW        = (K > 1) ? $clog2(K) : 1;
  localparam logic [TW-1:0]  TAIL_LAST = TW'(K - 2);

  enc_state_e    r_state;
  logic [K-2:0]  r_s;
  logic [TW-1:0] r_tailCnt;
  logic          r_outValid;
  logic          r_outLast;
  logic [1:0]    r_outSym;
  logic          r_frameDone;
  logic [15:0]   r_symCount;

  logic          w_slotFree;
  logic          w_inReady;
  logic          w_inFire;
  logic          w_tailFire;
  logic          w_load;
  logic          w_outFire;
  logic          w_dataBit;
  logic [K-1:0]  w_taps;
  logic          w_par1;
  logic          w_par0;

  // The output register can take a new symbol when empty or being drained
  // this cycle; both data bits and tail zeros compete for the same slot.
  assign w_slotFree = !r_outValid || bus.out_ready;
  assign w_inReady  = (r_state != TAIL) && w_slotFree;
  assign w_inFire   = bus.in_valid && w_inReady;
  assign w_tailFire = (r_state == TAIL) && w_slotFree;
  assign w_load     = w_inFire || w_tailFire;
  assign w_outFire  = r_outValid && bus.out_ready;

  // During TAIL the newest tap is forced to zero to flush the register.
  assign w_dataBit = (r_state == TAIL) ? 1'b0 : bus.in_bit;
  assign w_taps    = {w_dataBit, r_s};

  conv_parity #(.K(K)) u_parG0 (
    .i_taps   (w_taps),
    .i_poly   (G0),
    .o_parity (w_par1)
  );

  conv_parity #(.K(K)) u_parG1 (
    .i_taps   (w_taps),
    .i_poly   (G1),
    .o_parity (w_par0)
  );

  // Frame sequencer plus the registered output stage. The shift register
  // advances only when a symbol is actually produced, so stalls leave both
  // the state and the held symbol untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_s         <= '0;
      r_tailCnt   <= '0;
      r_outValid  <= 1'b0;
      r_outLast   <= 1'b0;
      r_outSym    <= 2'b00;
      r_frameDone <= 1'b0;
    end else begin
      if (w_load) begin
        r_s        <= w_taps[K-1:1];
        r_outSym   <= {w_par1, w_par0};
        r_outValid <= 1'b1;
        r_outLast  <= w_tailFire && (r_tailCnt == TAIL_LAST);
      end else if (bus.out_ready) begin
        r_outValid <= 1'b0;
        r_outLast  <= 1'b0;
      end

      case (r_state)
        IDLE, DATA: begin
          if (w_inFire) begin
            r_state <= bus.in_last ? TAIL : DATA;
          end
        end
        TAIL: begin
          if (w_tailFire) begin
            if (r_tailCnt == TAIL_LAST) begin
              r_state   <= IDLE;
              r_tailCnt <= '0;
            end else begin
              r_tailCnt <= r_tailCnt + TW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase

      r_frameDone <= w_outFire && r_outLast;
    end
  end

  // Symbols taken downstream this frame. The clear lands together with the
  // frame_done pulse; a first symbol of the next frame taken in that same
  // cycle is counted immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_symCount <= 16'd0;
    end else if (r_frameDone) begin
      r_symCount <= w_outFire ? 16'd1 : 16'd0;
    end else if (w_outFire && (r_symCount != 16'hFFFF)) begin
      r_symCount <= r_symCount + 16'd1;
    end
  end

  assign bus.in_ready   = w_inReady;
  assign bus.out_valid  = r_outValid;
  assign bus.out_sym    = r_outSym;
  assign bus.out_last   = r_outLast;
  assign bus.frame_done = r_frameDone;
  assign bus.sym_count  = r_symCount;

endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder. Expected symbols come from a direct
// convolution of each frame (data bits followed by K-1 zeros) against the
// generator polynomials; a per-cycle monitor compares the DUT to that model.
module tb_conv_encoder;

  import viterbi_pkg::*;

  typedef bit bitq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;

  conv_encoder_if bus();

  conv_encoder #(.K(K), .G0(G0), .G1(G1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int    checks    = 0;
  int    errors    = 0;
  int    expQ[$];
  bitq_t frameBits;
  int    obsLog[$];
  int    peakCount = 0;
  bit    inTail    = 0;
  int    expCount  = 0;
  bit    expDone   = 0;
  bit    prevStall = 0;
  logic [2:0] prevOut = '0;
  int    readyMode = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Symbol for position j of the tail-extended frame: sum over the K taps of
  // x[j-i] weighted by polynomial bit K-1-i (bits before the frame are zero).
  function automatic int convSym(input bitq_t xs, input int j);
    int p1 = 0;
    int p0 = 0;
    for (int i = 0; i < K; i++) begin
      int idx = j - i;
      int x   = (idx >= 0) ? int'(xs[idx]) : 0;
      if (G0[K-1-i]) p1 ^= x;
      if (G1[K-1-i]) p0 ^= x;
    end
    return p1 * 2 + p0;
  endfunction

  function automatic bitq_t mkBits(input int n, input logic [63:0] v);
    bitq_t q;
    for (int i = 0; i < n; i++) q.push_back(v[n-1-i]);
    return q;
  endfunction

  // Downstream ready pattern: 0 = always, 1 = repeating 1,0,0,1, 2 = random.
  initial begin
    int k = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0:       bus.out_ready = 1'b1;
        1: begin
          bus.out_ready = ((k % 4) == 0) || ((k % 4) == 3);
          k++;
        end
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares the DUT against the model on every falling edge.
  initial begin
    bit fire;
    bit poppedLast;
    int e;
    forever begin
      @(negedge clk);
      if (rst) begin
        expQ.delete();
        frameBits.delete();
        inTail    = 0;
        expCount  = 0;
        expDone   = 0;
        prevStall = 0;
        continue;
      end
      fire = bus.out_valid && bus.out_ready;
      if (bus.out_valid && bus.out_last) inTail = 0;

      checkOutput("in_ready", 32'(bus.in_ready), 32'(!inTail && (!bus.out_valid || bus.out_ready)));
      checkOutput("sym_count", 32'(bus.sym_count), 32'(expCount));
      checkOutput("frame_done", 32'(bus.frame_done), 32'(expDone));
      if (prevStall)
        checkOutput("stall_hold", 32'({bus.out_valid, bus.out_last, bus.out_sym}), 32'({1'b1, prevOut}));
      if (int'(bus.sym_count) > peakCount) peakCount = int'(bus.sym_count);

      poppedLast = 0;
      if (fire) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_symbol", 32'({bus.out_last, bus.out_sym}), 32'd8);
        end else begin
          e = expQ.pop_front();
          checkOutput("out_symbol", 32'({bus.out_last, bus.out_sym}), 32'(e));
          poppedLast = e[2];
        end
        obsLog.push_back(int'({bus.out_last, bus.out_sym}));
      end

      if (expDone)                       expCount = fire ? 1 : 0;
      else if (fire && expCount < 65535) expCount++;
      expDone = fire && poppedLast;

      if (bus.in_valid && bus.in_ready) begin
        frameBits.push_back(bus.in_bit);
        expQ.push_back(convSym(frameBits, frameBits.size() - 1));
        if (bus.in_last) begin
          inTail = 1;
          for (int t = 0; t < K - 1; t++) begin
            frameBits.push_back(1'b0);
            e = convSym(frameBits, frameBits.size() - 1);
            if (t == K - 2) e = e | 4;
            expQ.push_back(e);
          end
          frameBits.delete();
        end
      end

      prevStall = bus.out_valid && !bus.out_ready;
      prevOut   = {bus.out_last, bus.out_sym};
    end
  end

  // Presents each bit until it is accepted; called and returns at posedge+1.
  task automatic applyStimulus(input bitq_t bits, input bit gaps);
    for (int i = 0; i < bits.size(); i++) begin
      int  t = 0;
      bit  taken = 0;
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.in_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      bus.in_valid = 1'b1;
      bus.in_bit   = bits[i];
      bus.in_last  = (i == bits.size() - 1);
      while (!taken) begin
        @(negedge clk);
        taken = bus.in_ready;
        @(posedge clk);
        #1;
        t++;
        if (!taken && t > 300) begin
          checkOutput("accept_timeout", 32'(t), 32'd0);
          bus.in_valid = 1'b0;
          bus.in_last  = 1'b0;
          return;
        end
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (!(expQ.size() == 0 && !bus.out_valid)) begin
      @(negedge clk);
      n++;
      if (n > 3000) begin
        checkOutput("idle_timeout", 32'(n), 32'd0);
        break;
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Compares the captured symbol log to a list of hex digits {last,sym}, first symbol leftmost.
  task automatic checkLog(input string name, input int n, input logic [63:0] exp);
    checkOutput({name, "_len"}, 32'(obsLog.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      int act = (i < obsLog.size()) ? obsLog[i] : 15;
      checkOutput(name, 32'(act), 32'(exp[(n-1-i)*4 +: 4]));
    end
  endtask

  task automatic runDirected(input string name, input bitq_t bits, input int mode,
                             input int n, input logic [63:0] exp);
    obsLog.delete();
    peakCount = 0;
    readyMode = mode;
    applyStimulus(bits, 0);
    waitIdle();
    checkLog(name, n, exp);
  endtask

  initial begin
    bitq_t b;
    int    cnt;
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
    bus.in_last  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_sym", 32'(bus.out_sym), 32'd0);
    checkOutput("rst_out_last", 32'(bus.out_last), 32'd0);
    checkOutput("rst_frame_done", 32'(bus.frame_done), 32'd0);
    checkOutput("rst_sym_count", 32'(bus.sym_count), 32'd0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("ready_after_reset", 32'(bus.in_ready), 32'd1);

    // Pin the model to hand-worked values for 1,0,1,1 plus two tail zeros.
    b = mkBits(6, 64'b101100);
    begin
      logic [23:0] pin = 24'h320113;
      for (int j = 0; j < 6; j++)
        checkOutput("model_pin", 32'(convSym(b, j)), 32'(pin[(5-j)*4 +: 4]));
    end

    runDirected("frame_1011", mkBits(4, 64'b1011), 0, 6, 64'h320117);
    checkOutput("frame_1011_peak_count", 32'(peakCount), 32'd6);

    runDirected("frame_single", mkBits(1, 64'b1), 0, 3, 64'h327);

    runDirected("frame_stall", mkBits(4, 64'b1011), 1, 6, 64'h320117);
    checkOutput("frame_stall_peak_count", 32'(peakCount), 32'd6);

    // Reset in the middle of a frame: the frame must vanish without a tail.
    readyMode = 0;
    obsLog.delete();
    applyStimulus(mkBits(2, 64'b10), 0);
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midrst_out_last", 32'(bus.out_last), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    cnt = 0;
    foreach (obsLog[i]) if (obsLog[i][2]) cnt++;
    checkOutput("midrst_no_last", 32'(cnt), 32'd0);
    runDirected("after_reset", mkBits(4, 64'b1011), 0, 6, 64'h320117);
    checkOutput("after_reset_peak_count", 32'(peakCount), 32'd6);

    // Two frames offered back to back; the second waits out the first's tail.
    obsLog.delete();
    readyMode = 0;
    applyStimulus(mkBits(2, 64'b00), 0);
    applyStimulus(mkBits(1, 64'b1), 0);
    waitIdle();
    checkLog("back_to_back", 7, 64'h0004327);

    // Random frames with random gaps and downstream back-pressure.
    for (int f = 0; f < 30; f++) begin
      int len = (f == 0) ? 64 : int'($urandom_range(1, 64));
      b.delete();
      for (int i = 0; i < len; i++) b.push_back(1'($urandom_range(0, 1)));
      readyMode = int'($urandom_range(0, 2));
      applyStimulus(b, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) waitIdle();
    end
    waitIdle();
    checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_encoder.md
CONV_ENCODER -- requirements
Module: conv_encoder

Interface
REQ-001 Parameter K, default 3: constraint length; the encoder SHALL hold K-1 memory bits.
REQ-002 Parameter G0, default 3'b111: generator polynomial for output bit 1 (octal 7).
REQ-003 Parameter G1, default 3'b101: generator polynomial for output bit 0 (octal 5).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 in_valid  input  1  in_bit is valid this cycle.
REQ-007 in_ready  output  1  encoder accepts in_bit this cycle.
REQ-008 in_bit  input  1  information bit.
REQ-009 in_last  input  1  qualifies in_bit as the final data bit of the frame.
REQ-010 out_valid  output  1  out_sym is valid.
REQ-011 out_ready  input  1  downstream accepts out_sym.
REQ-012 out_sym  output  2  code symbol; bit 1 from G0, bit 0 from G1.
REQ-013 out_last  output  1  marks the final (tail) symbol of the frame.
REQ-014 frame_done  output  1  one-cycle pulse when the out_last symbol is accepted.
REQ-015 sym_count  output  16  count of symbols accepted in the current frame.

Function
REQ-016 Register s[K-2:0] SHALL hold previous bits, with s[K-2] the most recent; the tap vector SHALL be {in_bit, s}.
REQ-017 out_sym[1] SHALL be the XOR of the tap bits selected by G0, and out_sym[0] the XOR of those selected by G1.
REQ-018 A transfer SHALL occur when valid and ready are both high; in_bit is accepted on in_valid and in_ready.
REQ-019 out_sym, out_valid and out_last SHALL be registered, with a latency of 1 cycle from input acceptance to out_valid.
REQ-020 in_ready SHALL equal (state != TAIL) and (!out_valid or out_ready), so back-to-back input runs at 1 bit per cycle.
REQ-021 While out_valid is high and out_ready is low, out_sym and out_last SHALL hold stable.
REQ-022 FSM states: IDLE, DATA and TAIL.
REQ-023 In IDLE or DATA, acceptance of a bit without in_last SHALL move the FSM to DATA.
REQ-024 In IDLE or DATA, acceptance of a bit with in_last SHALL move the FSM to TAIL.
REQ-025 TAIL SHALL inject K-1 zero bits, one per output slot, gated by the same output-register availability.
REQ-026 The last tail symbol SHALL carry out_last=1; after it is generated the FSM SHALL return to IDLE with s at all zeros.
REQ-027 A tail counter of width clog2(K) SHALL count the injected zeros.
REQ-028 sym_count SHALL increment on each output transfer, saturate at 16'hFFFF, and clear on the cycle after the out_last transfer.
REQ-029 frame_done SHALL assert in the cycle after the out_last transfer.
REQ-030 If in_last arrives on the first bit in IDLE, the frame SHALL be 1 data symbol plus K-1 tail symbols.
REQ-031 A new frame SHALL NOT be accepted until the FSM is back in IDLE; in_ready stays low during TAIL.

Reset
REQ-032 rst SHALL force the FSM to IDLE, s to 0, the tail counter to 0, out_valid to 0, out_sym to 0, out_last to 0, frame_done to 0 and sym_count to 0.
REQ-033 After release of rst, in_ready SHALL be 1.
REQ-034 rst asserted mid-frame SHALL abandon the frame: no tail and no out_last are emitted.

Structure
REQ-035 K, G0, G1 and the state-count localparam SHALL live in the shared package viterbi_pkg, so the decoder's branch-metric and ACS trellis use identical polynomials.
REQ-036 The parity computation SHALL be a sub-module conv_parity (taps and polynomial in, 1 bit out), instantiated twice.

Verification
REQ-037 Scenario: bits 1,0,1,1 with in_last on the 4th bit, out_ready=1. Required: out_sym = 11,10,00,01,01,11; out_last on the 6th symbol; frame_done 1 cycle later; sym_count reaches 6.
REQ-038 Scenario: single bit 1 with in_last. Required: 11,10,11, out_last on the 3rd symbol.
REQ-039 Scenario: REQ-037 stream with out_ready toggling 1,0,0,1. Required: identical symbol sequence, out_sym stable while stalled, and no in_ready while out_valid is high and out_ready is low.
REQ-040 Scenario: rst pulsed after the 2nd bit of a frame. Required: out_valid=0 immediately, no out_last, and the next frame 1,0,1,1 reproduces the REQ-037 output.
REQ-041 Scenario: two frames back-to-back (0,0 last; then 1 last). Required: 00,00,00,00 then 11,10,11, with in_ready low during each TAIL.
REQ-042 Scenario: loopback of a random 64-bit frame into the Viterbi decoder. Required: decoded bits equal source bits and the final path metric is 0.
